// File: rtl/uart_tx_fifo.sv
// Show-ahead byte FIFO between the I2C read path and the UART transmitter.
// Head entry is presented on rd_data; status flags are registered from next-state usedw.
module uart_tx_fifo #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned ADDR_W    = 4,
  parameter int unsigned AFULL_LVL = 12
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              wr_req,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_req,
  output logic [DATA_W-1:0] rd_data,
  output logic              data_en,
  output logic              empty,
  output logic              full,
  output logic              almost_full,
  output logic [ADDR_W:0]   usedw,
  output logic              ovf_err,
  output logic              udf_err,
  input  logic              clr_err
);

  localparam int unsigned  DEPTH     = 1 << ADDR_W;
  localparam int unsigned  CNT_W     = ADDR_W + 1;
  localparam logic [ADDR_W:0] DEPTH_CNT = CNT_W'(DEPTH);
  localparam logic [ADDR_W:0] AFULL_CNT = CNT_W'(AFULL_LVL);

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   usedw_q,  usedw_d;
  logic              empty_q,  empty_d;
  logic              full_q,   full_d;
  logic              afull_q,  afull_d;
  logic              ovf_q,    ovf_d;
  logic              udf_q,    udf_d;
  logic              wr_ok,    rd_ok;

  // Acceptance, pointer/count update and status decode from the next count.
  always_comb begin
    wr_ok    = wr_req && (!full_q || rd_req);
    rd_ok    = rd_req && !empty_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    usedw_d  = usedw_q;
    ovf_d    = ovf_q;
    udf_d    = udf_q;

    if (wr_ok) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    if (rd_ok) rd_ptr_d = rd_ptr_q + ADDR_W'(1);

    case ({wr_ok, rd_ok})
      2'b10:   usedw_d = usedw_q + CNT_W'(1);
      2'b01:   usedw_d = usedw_q - CNT_W'(1);
      default: usedw_d = usedw_q;
    endcase

    empty_d = (usedw_d == '0);
    full_d  = (usedw_d == DEPTH_CNT);
    afull_d = (usedw_d >= AFULL_CNT);

    // Clear first so a same-cycle error event wins.
    if (clr_err) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end
    if (wr_req && !wr_ok)   ovf_d = 1'b1;
    if (rd_req && empty_q)  udf_d = 1'b1;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      usedw_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      afull_q  <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      usedw_q  <= usedw_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
      afull_q  <= afull_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // Storage array is intentionally not reset.
  always_ff @(posedge sys_clk) begin
    if (wr_ok) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data     = empty_q ? '0 : mem_q[rd_ptr_q];
  assign data_en     = !empty_q;
  assign empty       = empty_q;
  assign full        = full_q;
  assign almost_full = afull_q;
  assign usedw       = usedw_q;
  assign ovf_err     = ovf_q;
  assign udf_err     = udf_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed self-checking bench for uart_tx_fifo (16 x 8, almost_full at 12).
module tb_uart_tx_fifo;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n;
  logic       wr_req, rd_req, clr_err;
  logic [7:0] wr_data;
  logic [7:0] rd_data;
  logic       data_en, empty, full, almost_full, ovf_err, udf_err;
  logic [4:0] usedw;

  int tests = 0;
  int fails = 0;

  uart_tx_fifo #(.DATA_W(8), .ADDR_W(4), .AFULL_LVL(12)) dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .wr_req      (wr_req),
    .wr_data     (wr_data),
    .rd_req      (rd_req),
    .rd_data     (rd_data),
    .data_en     (data_en),
    .empty       (empty),
    .full        (full),
    .almost_full (almost_full),
    .usedw       (usedw),
    .ovf_err     (ovf_err),
    .udf_err     (udf_err),
    .clr_err     (clr_err)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_empty"}, 32'(empty), 32'd1);
    chk({tag, "_data_en"}, 32'(data_en), 32'd0);
    chk({tag, "_usedw"}, 32'(usedw), 32'd0);
    chk({tag, "_full"}, 32'(full), 32'd0);
    chk({tag, "_afull"}, 32'(almost_full), 32'd0);
    chk({tag, "_rd_data"}, 32'(rd_data), 32'h00);
    chk({tag, "_ovf"}, 32'(ovf_err), 32'd0);
    chk({tag, "_udf"}, 32'(udf_err), 32'd0);
  endtask

  initial begin
    sys_rst_n = 1'b0;
    wr_req = 1'b0; rd_req = 1'b0; clr_err = 1'b0; wr_data = 8'h00;
    step(); step();
    chk_reset_vals("rst_hold");
    sys_rst_n = 1'b1;
    step();
    chk_reset_vals("rst_rel");

    // Basic order
    wr_req = 1'b1; wr_data = 8'hA5; step();
    chk("bo_first_rd", 32'(rd_data), 32'hA5);
    chk("bo_first_en", 32'(data_en), 32'd1);
    chk("bo_first_empty", 32'(empty), 32'd0);
    wr_data = 8'h3C; step();
    wr_data = 8'h7E; step();
    wr_req = 1'b0;
    chk("bo_usedw3", 32'(usedw), 32'd3);
    chk("bo_head", 32'(rd_data), 32'hA5);
    rd_req = 1'b1; step(); rd_req = 1'b0;
    chk("bo_pop1", 32'(rd_data), 32'h3C);
    chk("bo_usedw2", 32'(usedw), 32'd2);
    rd_req = 1'b1; step(); rd_req = 1'b0;
    chk("bo_pop2", 32'(rd_data), 32'h7E);
    rd_req = 1'b1; step(); rd_req = 1'b0;
    chk("bo_empty", 32'(empty), 32'd1);
    chk("bo_rd_zero", 32'(rd_data), 32'h00);
    chk("bo_en_low", 32'(data_en), 32'd0);

    // Fill and overflow
    for (int i = 0; i < 17; i++) begin
      wr_req = 1'b1; wr_data = 8'(i); step();
      chk($sformatf("fill_usedw_%0d", i), 32'(usedw), (i < 16) ? 32'(i + 1) : 32'd16);
      chk($sformatf("fill_afull_%0d", i), 32'(almost_full), (i + 1 >= 12) ? 32'd1 : 32'd0);
      chk($sformatf("fill_full_%0d", i), 32'(full), (i + 1 >= 16) ? 32'd1 : 32'd0);
      chk($sformatf("fill_ovf_%0d", i), 32'(ovf_err), (i == 16) ? 32'd1 : 32'd0);
    end
    wr_req = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("drain_%0d", i), 32'(rd_data), 32'(i));
      rd_req = 1'b1; step(); rd_req = 1'b0;
    end
    chk("drain_empty", 32'(empty), 32'd1);
    chk("drain_usedw", 32'(usedw), 32'd0);
    clr_err = 1'b1; step(); clr_err = 1'b0;
    chk("ovf_cleared", 32'(ovf_err), 32'd0);

    // Simultaneous write+read when full
    for (int i = 0; i < 16; i++) begin
      wr_req = 1'b1; wr_data = 8'(8'h20 + i); step();
    end
    chk("sf_full", 32'(full), 32'd1);
    rd_req = 1'b1; wr_data = 8'h55; step();
    wr_req = 1'b0; rd_req = 1'b0;
    chk("sf_usedw", 32'(usedw), 32'd16);
    chk("sf_ovf", 32'(ovf_err), 32'd0);
    chk("sf_still_full", 32'(full), 32'd1);
    for (int i = 1; i < 16; i++) begin
      chk($sformatf("sf_drain_%0d", i), 32'(rd_data), 32'(8'h20 + i));
      rd_req = 1'b1; step(); rd_req = 1'b0;
    end
    chk("sf_last", 32'(rd_data), 32'h55);
    rd_req = 1'b1; step(); rd_req = 1'b0;
    chk("sf_empty", 32'(empty), 32'd1);

    // Simultaneous write+read when empty
    wr_req = 1'b1; rd_req = 1'b1; wr_data = 8'h66; step();
    wr_req = 1'b0; rd_req = 1'b0;
    chk("se_usedw", 32'(usedw), 32'd1);
    chk("se_udf", 32'(udf_err), 32'd1);
    chk("se_rd", 32'(rd_data), 32'h66);
    rd_req = 1'b1; step(); rd_req = 1'b0;
    chk("se_empty", 32'(empty), 32'd1);
    chk("se_udf_sticky", 32'(udf_err), 32'd1);

    // Error clear priority
    clr_err = 1'b1; step(); clr_err = 1'b0;
    chk("clr_udf", 32'(udf_err), 32'd0);
    clr_err = 1'b1; rd_req = 1'b1; step(); clr_err = 1'b0; rd_req = 1'b0;
    chk("clr_set_wins", 32'(udf_err), 32'd1);
    chk("clr_no_state", 32'(usedw), 32'd0);

    // Wrap-around with usedw held at 2
    wr_req = 1'b1; wr_data = 8'h80; step();
    wr_data = 8'h81; step();
    for (int i = 0; i < 40; i++) begin
      chk($sformatf("wrap_rd_%0d", i), 32'(rd_data), 32'(8'h80 + i));
      wr_req = 1'b1; rd_req = 1'b1; wr_data = 8'(8'h82 + i); step();
      chk($sformatf("wrap_usedw_%0d", i), 32'(usedw), 32'd2);
      chk($sformatf("wrap_flags_%0d", i), 32'({empty, full}), 32'd0);
    end
    wr_req = 1'b0; rd_req = 1'b0;
    chk("wrap_tail0", 32'(rd_data), 32'hA8);
    rd_req = 1'b1; step(); rd_req = 1'b0;
    chk("wrap_tail1", 32'(rd_data), 32'hA9);
    rd_req = 1'b1; step(); rd_req = 1'b0;
    chk("wrap_empty", 32'(empty), 32'd1);

    // Asynchronous reset mid-burst at usedw=5
    for (int i = 0; i < 5; i++) begin
      wr_req = 1'b1; wr_data = 8'(8'hC0 + i); step();
    end
    chk("mb_usedw5", 32'(usedw), 32'd5);
    #2 sys_rst_n = 1'b0;
    #1;
    chk_reset_vals("rst_async");
    wr_req = 1'b0;
    step();
    sys_rst_n = 1'b1;
    step();
    chk_reset_vals("rst_after");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
